// File: rtl/cache_addr_sequencer_pkg.sv
// Shared cache geometry: default sizes, derived field widths, FSM state type and address helpers.
package cache_geom_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_LINE_BYTES = 64;
    localparam int unsigned DEF_NUM_SETS   = 128;
    localparam int unsigned DEF_WORD_BYTES = 4;

    localparam int unsigned DEF_OFF_W = $clog2(DEF_LINE_BYTES);
    localparam int unsigned DEF_IDX_W = $clog2(DEF_NUM_SETS);
    localparam int unsigned DEF_TAG_W = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W;
    localparam int unsigned DEF_WB_W  = $clog2(DEF_WORD_BYTES);
    localparam int unsigned DEF_WPL   = DEF_LINE_BYTES / DEF_WORD_BYTES;
    localparam int unsigned DEF_WRD_W = $clog2(DEF_WPL);

    typedef struct packed {
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_IDX_W-1:0] index;
        logic [DEF_OFF_W-1:0] offset;
    } addr_fields_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SINGLE,
        S_BURST
    } seq_state_t;

    function automatic logic [DEF_WRD_W-1:0] word_of(input logic [DEF_OFF_W-1:0] offset);
        return DEF_WRD_W'(offset >> DEF_WB_W);
    endfunction

    function automatic logic [DEF_ADDR_W-1:0] line_base(input logic [DEF_ADDR_W-1:0] addr);
        return addr & ~(DEF_ADDR_W'(DEF_LINE_BYTES - 1));
    endfunction

endpackage

// File: rtl/cache_addr_sequencer_if.sv
// Request/beat handshake bundle between the request mux (master) and the address sequencer (slave).
import cache_geom_pkg::*;

interface cache_addr_sequencer_if #(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned TAG_W  = DEF_TAG_W,
    parameter int unsigned IDX_W  = DEF_IDX_W,
    parameter int unsigned OFF_W  = DEF_OFF_W,
    parameter int unsigned WRD_W  = DEF_WRD_W
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic              in_burst;
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [IDX_W-1:0]  out_index;
    logic [OFF_W-1:0]  out_offset;
    logic [WRD_W-1:0]  out_word;
    logic              out_first;
    logic              out_last;
    logic              out_misalign;

    modport master (
        output in_valid, in_addr, in_burst, out_ready,
        input  in_ready, out_valid, out_tag, out_index, out_offset,
               out_word, out_first, out_last, out_misalign
    );

    modport slave (
        input  in_valid, in_addr, in_burst, out_ready,
        output in_ready, out_valid, out_tag, out_index, out_offset,
               out_word, out_first, out_last, out_misalign
    );
endinterface

// File: rtl/cache_addr_sequencer_split.sv
// Combinational split of a byte address into tag / index / line offset plus word-misalignment flag.
import cache_geom_pkg::*;

module addr_field_split #(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned TAG_W  = DEF_TAG_W,
    parameter int unsigned IDX_W  = DEF_IDX_W,
    parameter int unsigned OFF_W  = DEF_OFF_W,
    parameter int unsigned WB_W   = DEF_WB_W
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [TAG_W-1:0]  tag,
    output logic [IDX_W-1:0]  index,
    output logic [OFF_W-1:0]  offset,
    output logic              misalign
);
    assign tag    = addr[ADDR_W-1 -: TAG_W];
    assign index  = addr[OFF_W +: IDX_W];
    assign offset = addr[OFF_W-1:0];

    // Byte-sized words can never be misaligned.
    if (WB_W == 0) begin : g_no_wb
        assign misalign = 1'b0;
    end else begin : g_wb
        assign misalign = |addr[WB_W-1:0];
    end
endmodule

// File: rtl/cache_addr_sequencer.sv
// Registered cache address decode stage: single-beat decode or critical-word-first whole-line bursts.
import cache_geom_pkg::*;

module cache_addr_sequencer #(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
    parameter int unsigned NUM_SETS   = DEF_NUM_SETS,
    parameter int unsigned WORD_BYTES = DEF_WORD_BYTES
) (
    input logic                  clk,
    input logic                  rst_n,
    cache_addr_sequencer_if.slave bus
);
    localparam int unsigned OFF_W = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int          TAG_S = int'(ADDR_W) - int'(IDX_W) - int'(OFF_W);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned WB_W  = $clog2(WORD_BYTES);
    localparam int unsigned WPL   = LINE_BYTES / WORD_BYTES;
    localparam int unsigned WRD_W = $clog2(WPL);

    if ((LINE_BYTES == 0) || ((LINE_BYTES & (LINE_BYTES - 1)) != 0)) begin : g_bad_line
        $error("LINE_BYTES must be a power of 2");
    end
    if ((NUM_SETS < 2) || ((NUM_SETS & (NUM_SETS - 1)) != 0)) begin : g_bad_sets
        $error("NUM_SETS must be a power of 2 and at least 2");
    end
    if ((WORD_BYTES == 0) || ((WORD_BYTES & (WORD_BYTES - 1)) != 0)) begin : g_bad_word
        $error("WORD_BYTES must be a power of 2");
    end
    if (LINE_BYTES < 2 * WORD_BYTES) begin : g_bad_wpl
        $error("LINE_BYTES must hold at least two words");
    end
    if (TAG_S < 1) begin : g_bad_tag
        $error("geometry leaves no tag bits");
    end

    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] f_index;
    logic [OFF_W-1:0] f_offset;
    logic             f_misalign;

    addr_field_split #(
        .ADDR_W (ADDR_W),
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W),
        .OFF_W  (OFF_W),
        .WB_W   (WB_W)
    ) u_split (
        .addr     (bus.in_addr),
        .tag      (f_tag),
        .index    (f_index),
        .offset   (f_offset),
        .misalign (f_misalign)
    );

    seq_state_t       state;
    logic [WRD_W-1:0] cnt;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] index_q;
    logic [OFF_W-1:0] offset_q;
    logic [WRD_W-1:0] word_q;
    logic             first_q;
    logic             misalign_q;

    logic             vld;
    logic             last;
    logic             consume;
    logic             ready;
    logic             accept;
    logic [WRD_W-1:0] word_nx;

    always_comb begin
        vld     = (state != S_IDLE);
        last    = (state == S_SINGLE) || ((state == S_BURST) && (cnt == '0));
        consume = vld && bus.out_ready;
        ready   = rst_n && ((state == S_IDLE) || (consume && last));
        accept  = bus.in_valid && ready;
        word_nx = word_q + 1'b1;
    end

    // Back-to-back accept takes priority over the final consume so the new request loads with no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            tag_q      <= '0;
            index_q    <= '0;
            offset_q   <= '0;
            word_q     <= '0;
            first_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (accept) begin
            tag_q      <= f_tag;
            index_q    <= f_index;
            offset_q   <= f_offset;
            word_q     <= WRD_W'(f_offset >> WB_W);
            first_q    <= 1'b1;
            misalign_q <= f_misalign;
            if (bus.in_burst && !f_misalign) begin
                state <= S_BURST;
                cnt   <= WRD_W'(WPL - 1);
            end else begin
                state <= S_SINGLE;
                cnt   <= '0;
            end
        end else if (consume) begin
            if (last) begin
                state <= S_IDLE;
            end else begin
                word_q   <= word_nx;
                offset_q <= OFF_W'(word_nx) << WB_W;
                cnt      <= cnt - 1'b1;
                first_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = ready;
    assign bus.out_valid    = vld;
    assign bus.out_tag      = tag_q;
    assign bus.out_index    = index_q;
    assign bus.out_offset   = offset_q;
    assign bus.out_word     = word_q;
    assign bus.out_first    = first_q;
    assign bus.out_last     = last;
    assign bus.out_misalign = misalign_q;
endmodule

// File: tb/tb_cache_addr_sequencer.sv
// Bench for cache_addr_sequencer at default geometry: queue-of-beats model plus directed literal checks.
module tb_cache_addr_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_addr_sequencer_if bus ();

    cache_addr_sequencer #(
        .ADDR_W     (32),
        .LINE_BYTES (64),
        .NUM_SETS   (128),
        .WORD_BYTES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int unsigned tag;
        int unsigned index;
        int unsigned offset;
        int unsigned word;
        bit          first;
        bit          last;
        bit          mis;
    } beat_t;

    typedef struct {
        int unsigned word;
        int unsigned offset;
        int unsigned index;
        bit          first;
        bit          last;
        int          cyc;
    } seen_t;

    int    n_checks = 0;
    int    n_err    = 0;
    int    cyc      = 0;
    beat_t q[$];
    seen_t seen[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Expected beats of one accepted request, from line geometry: 64-byte lines, 128 sets, 4-byte words.
    task automatic model_accept(input int unsigned addr, input bit burst);
        beat_t b;
        int unsigned w0;
        b.tag    = addr / 8192;
        b.index  = (addr / 64) % 128;
        b.mis    = (addr % 4) != 0;
        w0       = (addr % 64) / 4;
        if (burst && !b.mis) begin
            for (int k = 0; k < 16; k++) begin
                b.word   = (w0 + k) % 16;
                b.offset = b.word * 4;
                b.first  = (k == 0);
                b.last   = (k == 15);
                q.push_back(b);
            end
        end else begin
            b.word   = w0;
            b.offset = addr % 64;
            b.first  = 1'b1;
            b.last   = 1'b1;
            q.push_back(b);
        end
    endtask

    // Compare process: outputs are checked mid-cycle, then the model advances for the coming edge.
    always @(negedge clk) begin
        logic [38:0] got_b;
        logic [38:0] exp_b;
        bit          exp_ready;
        bit          cons;
        seen_t       s;
        cyc++;
        exp_ready = rst_n && ((q.size() == 0) || (q[0].last && bus.out_ready));
        chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            got_b = {bus.out_tag, bus.out_index, bus.out_offset, bus.out_word,
                     bus.out_first, bus.out_last, bus.out_misalign};
            exp_b = {19'(q[0].tag), 7'(q[0].index), 6'(q[0].offset), 4'(q[0].word),
                     q[0].first, q[0].last, q[0].mis};
            chk("beat", 64'(got_b), 64'(exp_b));
        end
        if (!rst_n) begin
            q.delete();
        end else begin
            cons = (q.size() != 0) && bus.out_ready;
            if (cons) begin
                s.word   = bus.out_word;
                s.offset = bus.out_offset;
                s.index  = bus.out_index;
                s.first  = bus.out_first;
                s.last   = bus.out_last;
                s.cyc    = cyc;
                seen.push_back(s);
                void'(q.pop_front());
            end
            if (bus.in_valid && exp_ready)
                model_accept(bus.in_addr, bus.in_burst);
        end
    end

    task automatic send(input logic [31:0] a, input logic b);
        logic acc;
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_burst = b;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_seen(input int n);
        for (int i = 0; i < 100 && seen.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        chk("beat_count", 64'(seen.size()), 64'(n));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_w[16];
        exp_w = '{14, 15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_burst  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_fields", 64'({bus.out_tag, bus.out_index, bus.out_offset, bus.out_word,
                               bus.out_first, bus.out_last, bus.out_misalign}), 64'd0);
        rst_n = 1'b1;
        step();

        // single beat
        bus.out_ready = 1'b1;
        send(32'h1234_5678, 1'b0);
        bus.in_valid = 1'b0;
        chk("s_tag", 64'(bus.out_tag), 64'h091A2);
        chk("s_index", 64'(bus.out_index), 64'h59);
        chk("s_offset", 64'(bus.out_offset), 64'h38);
        chk("s_word", 64'(bus.out_word), 64'd14);
        chk("s_flags", 64'({bus.out_first, bus.out_last, bus.out_misalign}), 64'b110);
        step();
        chk("s_idle", 64'(bus.out_valid), 64'd0);

        // critical-word-first burst
        seen.delete();
        send(32'h1234_5678, 1'b1);
        bus.in_valid = 1'b0;
        wait_seen(16);
        for (int i = 0; i < 16 && i < seen.size(); i++) begin
            chk("b_word", 64'(seen[i].word), 64'(exp_w[i]));
            chk("b_offset", 64'(seen[i].offset), 64'(exp_w[i] * 4));
            chk("b_first_last", 64'({seen[i].first, seen[i].last}), 64'({i == 0, i == 15}));
        end

        // misaligned burst demoted to a single beat
        send(32'h0000_0041, 1'b1);
        bus.in_valid = 1'b0;
        chk("m_index", 64'(bus.out_index), 64'd1);
        chk("m_offset", 64'(bus.out_offset), 64'h01);
        chk("m_word", 64'(bus.out_word), 64'd0);
        chk("m_flags", 64'({bus.out_first, bus.out_last, bus.out_misalign}), 64'b111);
        step();
        chk("m_idle", 64'(bus.out_valid), 64'd0);

        // backpressure at beat 5
        seen.delete();
        send(32'h0000_0000, 1'b1);
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", 64'({bus.out_valid, bus.out_word}), 64'({1'b1, 4'd5}));
            step();
        end
        bus.out_ready = 1'b1;
        wait_seen(16);
        for (int i = 0; i < 16 && i < seen.size(); i++)
            chk("bp_word", 64'(seen[i].word), 64'(i));

        // back-to-back singles
        seen.delete();
        send(32'h40, 1'b0);
        send(32'h80, 1'b0);
        send(32'hC0, 1'b0);
        bus.in_valid = 1'b0;
        wait_seen(3);
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            chk("bb_index", 64'(seen[i].index), 64'(i + 1));
            chk("bb_gap", 64'(seen[i].cyc - seen[0].cyc), 64'(i));
        end

        // reset during beat 7
        send(32'h0000_0000, 1'b1);
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("r_beat7", 64'(bus.out_word), 64'd7);
        rst_n = 1'b0;
        step();
        chk("r_valid", 64'(bus.out_valid), 64'd0);
        chk("r_ready_low", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("r_ready", 64'(bus.in_ready), 64'd1);
        step();
        step();
        chk("r_no_residual", 64'(bus.out_valid), 64'd0);
        send(32'h1234_5678, 1'b0);
        bus.in_valid = 1'b0;
        chk("r_tag", 64'(bus.out_tag), 64'h091A2);
        chk("r_word", 64'(bus.out_word), 64'd14);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
